// File: rtl/mem_pkg.sv
// Shared encodings for the memory stage: funct3 codes, result-select values, FSM states
// and access-size helpers.
package mem_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    localparam logic [1:0] RESULT_ALU = 2'b00;
    localparam logic [1:0] RESULT_MEM = 2'b01;
    localparam logic [1:0] RESULT_PC4 = 2'b10;

    typedef enum logic {IDLE, WAIT} mem_state_e;

    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} access_size_e;

    // Undefined funct3 values fall through to a word access.
    function automatic access_size_e access_size(input logic [2:0] mem_type);
        case (mem_type)
            LB, LBU: return SZ_BYTE;
            LH, LHU: return SZ_HALF;
            default: return SZ_WORD;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] mem_type, input logic [1:0] addr_lo);
        case (access_size(mem_type))
            SZ_HALF: return addr_lo[0];
            SZ_WORD: return addr_lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores and lane select plus sign/zero extension for loads.
module lsu_align
    import mem_pkg::*;
(
    input  logic [2:0]  i_mem_type,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_wstrb,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);

    access_size_e w_size;
    logic         w_sext;
    logic [7:0]   w_byte;
    logic [15:0]  w_half;

    assign w_size = access_size(i_mem_type);
    assign w_sext = ~i_mem_type[2];
    assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

    always_comb begin
        unique case (i_addr_lo)
            2'd0: w_byte = i_rdata[7:0];
            2'd1: w_byte = i_rdata[15:8];
            2'd2: w_byte = i_rdata[23:16];
            2'd3: w_byte = i_rdata[31:24];
        endcase
    end

    always_comb begin
        o_wstrb = 4'b1111;
        o_wdata = i_wdata;
        o_rdata = i_rdata;
        case (w_size)
            SZ_BYTE: begin
                o_wstrb = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_wdata[7:0]}};
                o_rdata = {{24{w_sext & w_byte[7]}}, w_byte};
            end
            SZ_HALF: begin
                // a[0] is ignored here; the trap build catches it upstream.
                o_wstrb = 4'b0011 << {i_addr_lo[1], 1'b0};
                o_wdata = {2{i_wdata[15:0]}};
                o_rdata = {{16{w_sext & w_half[15]}}, w_half};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage: EX/MEM register, data-memory req/ack handshake and load/store alignment.
// Define MEM_MISALIGN_TRAP_EN to add the MisalignM output and suppress misaligned requests.
module mem_stage
    import mem_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              RegWriteE,
    input  logic [1:0]        ResultSrcE,
    input  logic              MemWriteE,
    input  logic [2:0]        MemTypeE,
    input  logic [DATA_W-1:0] ALUResultE,
    input  logic [DATA_W-1:0] WriteDataE,
    input  logic [4:0]        RdE,
    input  logic [DATA_W-1:0] PCPlus4E,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [3:0]        mem_wstrb,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              StallM,
`ifdef MEM_MISALIGN_TRAP_EN
    output logic              MisalignM,
`endif
    output logic              RegWriteM,
    output logic [1:0]        ResultSrcM,
    output logic [4:0]        RdM,
    output logic [DATA_W-1:0] ALUResultM,
    output logic [DATA_W-1:0] PCPlus4M,
    output logic [DATA_W-1:0] ReadDataM
);

    logic              r_reg_write;
    logic [1:0]        r_result_src;
    logic              r_mem_write;
    logic [2:0]        r_mem_type;
    logic [DATA_W-1:0] r_alu_result;
    logic [DATA_W-1:0] r_write_data;
    logic [4:0]        r_rd;
    logic [DATA_W-1:0] r_pc_plus4;
    mem_state_e        r_state;

    logic              w_mem_op;
    logic              w_misalign;
    logic [3:0]        w_wstrb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_reg_write  <= 1'b0;
            r_result_src <= RESULT_ALU;
            r_mem_write  <= 1'b0;
            r_mem_type   <= 3'b000;
            r_alu_result <= '0;
            r_write_data <= '0;
            r_rd         <= 5'd0;
            r_pc_plus4   <= '0;
        end else if (!StallM) begin
            r_reg_write  <= RegWriteE;
            r_result_src <= ResultSrcE;
            r_mem_write  <= MemWriteE;
            r_mem_type   <= MemTypeE;
            r_alu_result <= ALUResultE;
            r_write_data <= WriteDataE;
            r_rd         <= RdE;
            r_pc_plus4   <= PCPlus4E;
        end
    end

    assign w_mem_op = r_mem_write | (r_result_src == RESULT_MEM);

`ifdef MEM_MISALIGN_TRAP_EN
    assign w_misalign = w_mem_op & is_misaligned(r_mem_type, r_alu_result[1:0]);
    assign MisalignM  = w_misalign;
`else
    assign w_misalign = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            unique case (r_state)
                IDLE: if (mem_req && !mem_ack) r_state <= WAIT;
                WAIT: if (mem_ack) r_state <= IDLE;
            endcase
        end
    end

    // The EX/MEM register is frozen in WAIT, so the request stays stable until ack.
    assign mem_req   = (r_state == WAIT) | (w_mem_op & ~w_misalign);
    assign StallM    = mem_req & ~mem_ack;
    assign mem_we    = r_mem_write & ~w_misalign;
    assign mem_addr  = {r_alu_result[DATA_W-1:2], 2'b00};
    assign mem_wstrb = mem_we ? w_wstrb : 4'b0000;

    lsu_align u_lsu_align (
        .i_mem_type (r_mem_type),
        .i_addr_lo  (r_alu_result[1:0]),
        .i_wdata    (r_write_data),
        .i_rdata    (mem_rdata),
        .o_wstrb    (w_wstrb),
        .o_wdata    (mem_wdata),
        .o_rdata    (ReadDataM)
    );

    assign RegWriteM  = r_reg_write & ~w_misalign;
    assign ResultSrcM = r_result_src;
    assign RdM        = r_rd;
    assign ALUResultM = r_alu_result;
    assign PCPlus4M   = r_pc_plus4;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed vectors, a behavioural model and literal checks.
module tb_mem_stage;
    import mem_pkg::*;

    typedef struct packed {
        logic        rw;
        logic [1:0]  rs;
        logic        mw;
        logic [2:0]  mt;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [4:0]  rd;
        logic [31:0] pc4;
    } ex_t;

    logic        clk = 1'b0;
    logic        rst_n;
    ex_t         e_in;
    logic        mem_req, mem_we, mem_ack, StallM, RegWriteM;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, ALUResultM, PCPlus4M, ReadDataM;
    logic [3:0]  mem_wstrb;
    logic [1:0]  ResultSrcM;
    logic [4:0]  RdM;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        MisalignM;
`endif

    mem_stage #(.DATA_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .RegWriteE  (e_in.rw),
        .ResultSrcE (e_in.rs),
        .MemWriteE  (e_in.mw),
        .MemTypeE   (e_in.mt),
        .ALUResultE (e_in.alu),
        .WriteDataE (e_in.wd),
        .RdE        (e_in.rd),
        .PCPlus4E   (e_in.pc4),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wstrb  (mem_wstrb),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .StallM     (StallM),
`ifdef MEM_MISALIGN_TRAP_EN
        .MisalignM  (MisalignM),
`endif
        .RegWriteM  (RegWriteM),
        .ResultSrcM (ResultSrcM),
        .RdM        (RdM),
        .ALUResultM (ALUResultM),
        .PCPlus4M   (PCPlus4M),
        .ReadDataM  (ReadDataM)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    function automatic int nbytes(input logic [2:0] t);
        if (t == 3'd0 || t == 3'd4) return 1;
        if (t == 3'd1 || t == 3'd5) return 2;
        return 4;
    endfunction

    function automatic int lane_off(input ex_t x);
        int a = int'(x.alu[1:0]);
        int n = nbytes(x.mt);
        if (n == 4) return 0;
        if (n == 2) return (a / 2) * 2;
        return a;
    endfunction

    function automatic logic is_memop(input ex_t x);
        return x.mw || (x.rs == 2'b01);
    endfunction

    function automatic logic model_mis(input ex_t x);
`ifdef MEM_MISALIGN_TRAP_EN
        int a = int'(x.alu[1:0]);
        int n = nbytes(x.mt);
        return is_memop(x) && ((n == 2 && (a % 2) != 0) || (n == 4 && a != 0));
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] model_load(input ex_t x, input logic [31:0] rdata);
        int n = nbytes(x.mt);
        logic [31:0] v;
        if (n == 4) return rdata;
        v = (rdata >> (8 * lane_off(x))) & ((n == 1) ? 32'hFF : 32'hFFFF);
        if (!x.mt[2] && v >= ((n == 1) ? 32'h80 : 32'h8000))
            v = v + ((n == 1) ? 32'hFFFF_FF00 : 32'hFFFF_0000);
        return v;
    endfunction

    function automatic logic [31:0] model_strb(input ex_t x);
        int n = nbytes(x.mt);
        if (n == 4) return 32'hF;
        return ((n == 1) ? 32'h1 : 32'h3) << lane_off(x);
    endfunction

    function automatic logic [31:0] model_wdata(input ex_t x);
        int n = nbytes(x.mt);
        if (n == 1) return (x.wd & 32'hFF) * 32'h0101_0101;
        if (n == 2) return (x.wd & 32'hFFFF) * 32'h0001_0001;
        return x.wd;
    endfunction

    ex_t m;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '0;
        else if (!(is_memop(m) && !model_mis(m) && !mem_ack)) m <= e_in;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            logic req;
            req = is_memop(m) && !model_mis(m);
            chk("mem_req", {31'd0, mem_req}, {31'd0, req});
            chk("StallM", {31'd0, StallM}, {31'd0, req && !mem_ack});
            chk("RegWriteM", {31'd0, RegWriteM}, {31'd0, m.rw && !model_mis(m)});
            chk("ResultSrcM", {30'd0, ResultSrcM}, {30'd0, m.rs});
            chk("RdM", {27'd0, RdM}, {27'd0, m.rd});
            chk("ALUResultM", ALUResultM, m.alu);
            chk("PCPlus4M", PCPlus4M, m.pc4);
`ifdef MEM_MISALIGN_TRAP_EN
            chk("MisalignM", {31'd0, MisalignM}, {31'd0, model_mis(m)});
`endif
            if (req) begin
                chk("mem_we", {31'd0, mem_we}, {31'd0, m.mw});
                chk("mem_addr", mem_addr, (m.alu / 4) * 4);
                chk("mem_wstrb", {28'd0, mem_wstrb}, m.mw ? model_strb(m) : 32'h0);
                if (m.mw) chk("mem_wdata", mem_wdata, model_wdata(m));
                else if (mem_ack) chk("ReadDataM", ReadDataM, model_load(m, mem_rdata));
            end
        end
    end

    // ---------------- stimulus ----------------
    function automatic ex_t alu_op(input logic [4:0] rd, input logic [31:0] v);
        ex_t x = '0;
        x.rw = 1'b1; x.rs = RESULT_ALU; x.alu = v; x.rd = rd; x.pc4 = v + 32'd4;
        return x;
    endfunction

    function automatic ex_t ld(input logic [2:0] t, input logic [31:0] a, input logic [4:0] rd);
        ex_t x = '0;
        x.rw = 1'b1; x.rs = RESULT_MEM; x.mt = t; x.alu = a; x.rd = rd; x.pc4 = a ^ 32'h40;
        return x;
    endfunction

    function automatic ex_t st(input logic [2:0] t, input logic [31:0] a, input logic [31:0] wd);
        ex_t x = '0;
        x.mw = 1'b1; x.mt = t; x.alu = a; x.wd = wd; x.pc4 = a + 32'd8;
        return x;
    endfunction

    // Drive E inputs and the memory response for the current M instruction, then stop at negedge.
    task automatic tick(input ex_t e, input logic ack, input logic [31:0] rdata);
        @(posedge clk);
        #1;
        e_in      = e;
        mem_ack   = ack;
        mem_rdata = rdata;
        @(negedge clk);
    endtask

    logic [2:0] ld_types [5];
    logic [2:0] st_types [3];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        ld_types = '{LB, LH, LW, LBU, LHU};
        st_types = '{SB, SH, SW};
        rst_n     = 1'b0;
        e_in      = '0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        #3;
        chk("reset mem_req", {31'd0, mem_req}, 32'd0);
        chk("reset mem_we", {31'd0, mem_we}, 32'd0);
        chk("reset mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
        chk("reset StallM", {31'd0, StallM}, 32'd0);
        chk("reset RegWriteM", {31'd0, RegWriteM}, 32'd0);
        chk("reset ALUResultM", ALUResultM, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        tick(alu_op(5'd5, 32'h1234), 1'b0, 32'h0);
        tick(st(SB, 32'h1003, 32'h0000_00A5), 1'b0, 32'h0);
        chk("alu RegWriteM", {31'd0, RegWriteM}, 32'd1);
        chk("alu mem_req", {31'd0, mem_req}, 32'd0);
        tick(ld(LB, 32'h2001, 5'd7), 1'b1, 32'h0);
        chk("SB wstrb", {28'd0, mem_wstrb}, 32'h8);
        chk("SB wdata", mem_wdata, 32'hA5A5_A5A5);
        chk("SB addr", mem_addr, 32'h1000);
        chk("SB StallM", {31'd0, StallM}, 32'd0);
        tick('0, 1'b0, 32'h0);
        chk("LB wait1 StallM", {31'd0, StallM}, 32'd1);
        tick('0, 1'b0, 32'h0);
        chk("LB wait2 StallM", {31'd0, StallM}, 32'd1);
        tick(ld(LHU, 32'h0002, 5'd8), 1'b1, 32'h0000_F000);
        chk("LB ack StallM", {31'd0, StallM}, 32'd0);
        chk("LB ReadDataM", ReadDataM, 32'hFFFF_FFF0);
        tick(ld(LH, 32'h0002, 5'd9), 1'b1, 32'h8001_0000);
        chk("LHU ReadDataM", ReadDataM, 32'h0000_8001);
        tick(ld(LW, 32'h3002, 5'd10), 1'b1, 32'h8001_0000);
        chk("LH ReadDataM", ReadDataM, 32'hFFFF_8001);
        tick(st(SW, 32'h0040, 32'hDEAD_BEEF), 1'b1, 32'h1122_3344);
`ifdef MEM_MISALIGN_TRAP_EN
        chk("LW mis mem_req", {31'd0, mem_req}, 32'd0);
        chk("LW mis MisalignM", {31'd0, MisalignM}, 32'd1);
        chk("LW mis RegWriteM", {31'd0, RegWriteM}, 32'd0);
`else
        chk("LW mem_req", {31'd0, mem_req}, 32'd1);
        chk("LW addr", mem_addr, 32'h3000);
        chk("LW ReadDataM", ReadDataM, 32'h1122_3344);
`endif
        tick('0, 1'b1, 32'h0);
        chk("SW b2b mem_req", {31'd0, mem_req}, 32'd1);
        chk("SW StallM", {31'd0, StallM}, 32'd0);
        chk("SW wstrb", {28'd0, mem_wstrb}, 32'hF);
        tick(st(SH, 32'h0006, 32'h1234_BEEF), 1'b1, 32'h0);
        chk("stray ack StallM", {31'd0, StallM}, 32'd0);
        tick(ld(LBU, 32'h0003, 5'd11), 1'b1, 32'h0);
        chk("SH wstrb", {28'd0, mem_wstrb}, 32'hC);
        chk("SH wdata", mem_wdata, 32'hBEEF_BEEF);
        tick('0, 1'b1, 32'h8000_0000);
        chk("LBU ReadDataM", ReadDataM, 32'h0000_0080);

        for (int i = 0; i < 20; i++)
            tick(ld(ld_types[i / 4], 32'h500 + 32'(i % 4), 5'(i + 1)), (i % 3) != 0,
                 32'hF0E1_D2C3 ^ 32'(i * 32'h0101));
        for (int i = 0; i < 12; i++)
            tick(st(st_types[i / 4], 32'h600 + 32'(i % 4), 32'h89AB_CDEF + 32'(i)), (i % 4) != 1,
                 32'h0);
        tick('0, 1'b1, 32'h0);

        // Reset while a load is waiting for its ack.
        tick(ld(LW, 32'h0100, 5'd3), 1'b1, 32'h0);
        tick('0, 1'b0, 32'h0);
        chk("pre-reset StallM", {31'd0, StallM}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid-reset mem_req", {31'd0, mem_req}, 32'd0);
        chk("mid-reset StallM", {31'd0, StallM}, 32'd0);
        e_in    = '0;
        mem_ack = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick(ld(LW, 32'h0104, 5'd4), 1'b0, 32'h0);
        chk("post-reset RegWriteM", {31'd0, RegWriteM}, 32'd0);
        chk("post-reset mem_req", {31'd0, mem_req}, 32'd0);
        tick('0, 1'b1, 32'h0000_0055);
        chk("post-reset LW StallM", {31'd0, StallM}, 32'd0);
        chk("post-reset LW ReadDataM", ReadDataM, 32'h0000_0055);
        tick('0, 1'b0, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Pipeline memory stage, directly downstream of the execute stage. Registers execute-stage results into an EX/MEM pipeline register. For loads and stores it runs a request/acknowledge transaction on the data-memory port, with byte-lane alignment and sign or zero extension. It asserts a stall to the hazard unit while a transaction is outstanding, and presents M-stage results to writeback and forwarding.

## Interface
- DATA_W, 32, datapath width; only 32 is supported
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- RegWriteE  in  1  register-file write enable from execute
- ResultSrcE  in  2  result select: 00 ALU, 01 load data, 10 PC+4
- MemWriteE  in  1  store
- MemTypeE  in  3  funct3 of the load/store
- ALUResultE  in  32  effective address or ALU result
- WriteDataE  in  32  forwarded rs2, the store data
- RdE  in  5  destination register
- PCPlus4E  in  32  link value
- mem_req  out  1  data-memory request
- mem_we  out  1  write request
- mem_addr  out  32  word-aligned address ({ALUResultM[31:2],2'b00})
- mem_wstrb  out  4  byte write strobes
- mem_wdata  out  32  lane-replicated store data
- mem_ack  in  1  request accepted and completed this cycle
- mem_rdata  in  32  read word, valid when mem_ack=1
- StallM  out  1  freeze PC, IF/ID, ID/EX and this stage's register
- RegWriteM, ResultSrcM, RdM, ALUResultM, PCPlus4M  out  1/2/5/32/32  registered control and data
- ReadDataM  out  32  aligned and extended load result
- MisalignM  out  1  misaligned access detected; exists only when the macro is enabled

## Operation
- EX/MEM register captures all *E inputs on a rising edge when StallM=0. It holds when StallM=1.
- MemOpM = MemWriteM | (ResultSrcM==01).
- FSM states: IDLE and WAIT.
  - IDLE: mem_req = MemOpM. If mem_ack=0, go to WAIT.
  - WAIT: mem_req=1. When mem_ack=1, go to IDLE.
- StallM = mem_req & ~mem_ack.
- mem_we, mem_addr, mem_wstrb and mem_wdata derive from EX/MEM register contents. They are stable for the whole request.
- Store byte (MemType 000): wstrb = 0001<<a[1:0]; wdata = {4{wd[7:0]}}.
- Store half (001): wstrb = 0011<<{a[1],0}; wdata = {2{wd[15:0]}}.
- Store word (010): wstrb = 1111.
- Load: mem_wstrb = 0000. Select lane by a[1:0], then apply extension:
  - LB (000) / LH (001): sign-extend
  - LW (010): full word
  - LBU (100) / LHU (101): zero-extend
- ReadDataM is combinational from mem_rdata. It is valid only in the mem_ack cycle.
- Non-memory instructions pass through with mem_req=0 and no stall.
- Undefined MemType values are treated as a word access.

## Timing
- Reset: all EX/MEM fields are 0, FSM is IDLE. mem_req, mem_we, mem_wstrb, StallM and MisalignM are all 0.
- Reset asserted mid-transaction drops mem_req immediately, with no handshake completion.
- Zero-wait memory: mem_ack in the first request cycle means no stall, and the stage advances every cycle.
- N wait cycles: StallM is high for N cycles. The register advances on the edge after the ack cycle.
- Back-to-back memory ops: the next request is asserted in the cycle right after an ack. There is no idle bubble.
- A mem_ack arriving while mem_req=0 is ignored.

## Configuration
- MEM_MISALIGN_TRAP_EN defined:
  - Misaligned cases: half with a[0]=1, or word with a[1:0]!=00.
  - Response: mem_req is suppressed, MisalignM=1 for that M cycle, RegWriteM is forced to 0, and there is no stall.
- MEM_MISALIGN_TRAP_EN undefined: the MisalignM port is absent. Offending low address bits are ignored, so half uses a[1] and word uses a[1:0]=00.

## Structure
- Package mem_pkg holds:
  - funct3 localparams: LB, LH, LW, LBU, LHU, SB, SH, SW
  - RESULT_* encodings
  - the FSM state enum {IDLE, WAIT}
- Sub-module lsu_align, combinational. It produces wstrb and wdata for stores and the extended ReadData for loads, given MemType, a[1:0] and the raw data.

## Test plan
- Zero-wait store: SB, a=0x1003, wd=0x000000A5, ack in the same cycle → mem_wstrb=1000, mem_wdata=0xA5A5A5A5, mem_addr=0x1000, StallM=0.
- LB with 2 wait states: a=0x2001, mem_rdata=0x0000F000 on the ack cycle → StallM high 2 cycles, ReadDataM=0xFFFFFFF0.
- LHU versus LH on a[1]=1 with mem_rdata=0x80010000 → ReadDataM=0x00008001 (LHU) and 0xFFFF8001 (LH).
- Back-to-back LW then SW, both zero-wait → mem_req high two consecutive cycles, no stall, no bubble.
- rst_n pulled low during WAIT → mem_req and StallM are 0 immediately. After release: FSM IDLE, RegWriteM=0.
- With MEM_MISALIGN_TRAP_EN: LW at a=0x3002 → mem_req=0, MisalignM=1, RegWriteM=0. Without the macro → mem_addr=0x3000, normal load.
